lookup_stage: RTL and testbench



---
 rtl/lookup_pkg.sv | 33 +++
 rtl/lookup_stage_if.sv | 45 ++++
 rtl/lookup_stage.sv | 100 ++++++++++
 tb/tb_lookup_stage.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lookup_pkg.sv
// Shared definitions for the range-lookup tree levels: node-word layout,
// default widths, record types and an elaboration-time width check.
package lookup_pkg;

   localparam int KEY_W    = 32;
   localparam int RESULT_W = 39;
   localparam int ADDR_W   = 10;
   localparam int DATA_W   = KEY_W + RESULT_W + 1;

   // Node word: {node_key, node_result, node_valid}, valid in bit 0.
   localparam int NODE_VALID_BIT  = 0;
   localparam int NODE_RESULT_LSB = 1;

   typedef struct packed {
      logic [KEY_W-1:0]    key;
      logic [RESULT_W-1:0] result;
      logic                valid;
   } node_t;

   typedef struct packed {
      logic [KEY_W-1:0]    key;
      logic [ADDR_W-1:0]   addr;
      logic [RESULT_W-1:0] result;
      logic                hit;
   } token_t;

   function automatic bit widths_ok(input int key_w, input int result_w,
                                    input int data_w, input int addr_w,
                                    input int stage_id);
      return (data_w == key_w + result_w + 1) && (addr_w >= stage_id + 1);
   endfunction

endpackage

// File: rtl/lookup_stage_if.sv
// Token, update and BRAM-port bundle of one lookup level.
interface lookup_stage_if #(
   parameter int KEY    = 32,
   parameter int RESULT = 39,
   parameter int ADDR   = 10,
   parameter int DATA   = 72
);
   logic              in_valid;
   logic [KEY-1:0]    in_key;
   logic [ADDR-1:0]   in_addr;
   logic [RESULT-1:0] in_result;
   logic              in_hit;

   logic              out_valid;
   logic [KEY-1:0]    out_key;
   logic [ADDR-1:0]   out_addr;
   logic [RESULT-1:0] out_result;
   logic              out_hit;

   logic              upd_valid;
   logic [ADDR-1:0]   upd_addr;
   logic [DATA-1:0]   upd_data;
   logic              upd_ack;

   logic [ADDR-1:0]   mem_a_addr;
   logic [DATA-1:0]   mem_a_dout;
   logic              mem_b_wr;
   logic [ADDR-1:0]   mem_b_addr;
   logic [DATA-1:0]   mem_b_din;

   // master: upstream level, host and the BRAM; slave: the lookup stage
   modport master (
      output in_valid, in_key, in_addr, in_result, in_hit,
      output upd_valid, upd_addr, upd_data, mem_a_dout,
      input  out_valid, out_key, out_addr, out_result, out_hit,
      input  upd_ack, mem_a_addr, mem_b_wr, mem_b_addr, mem_b_din
   );

   modport slave (
      input  in_valid, in_key, in_addr, in_result, in_hit,
      input  upd_valid, upd_addr, upd_data, mem_a_dout,
      output out_valid, out_key, out_addr, out_result, out_hit,
      output upd_ack, mem_a_addr, mem_b_wr, mem_b_addr, mem_b_din
   );
endinterface

// File: rtl/lookup_stage.sv
// One level of the pipelined range-lookup tree: reads the node on port A,
// compares, emits the child token two cycles later; registers host writes on port B.
module lookup_stage
   import lookup_pkg::*;
#(
   parameter int STAGE_ID = 0,
   parameter int KEY      = 32,
   parameter int RESULT   = 39,
   parameter int ADDR     = 10,
   parameter int DATA     = 72,
   parameter int CNT      = 32
) (
   input  logic           clk,
   input  logic           rst,
   lookup_stage_if.slave  bus,
   output logic [CNT-1:0] lookup_cnt,
   output logic [CNT-1:0] hit_cnt
);

   generate
      if (!widths_ok(KEY, RESULT, DATA, ADDR, STAGE_ID)) begin : g_bad_widths
         $error("lookup_stage: DATA must equal KEY+RESULT+1 and ADDR must be >= STAGE_ID+1");
      end
   endgenerate

   typedef struct packed {
      logic [KEY-1:0]    key;
      logic [ADDR-1:0]   addr;
      logic [RESULT-1:0] result;
      logic              hit;
   } tok_t;

   logic              s1_valid;
   tok_t              s1;
   logic              o_valid;
   tok_t              o;
   logic              b_wr;
   logic [ADDR-1:0]   b_addr;
   logic [DATA-1:0]   b_din;

   logic [KEY-1:0]    node_key;
   logic [RESULT-1:0] node_result;
   logic              node_valid;
   logic              go_right;

   assign node_key    = bus.mem_a_dout[DATA-1 -: KEY];
   assign node_result = bus.mem_a_dout[NODE_RESULT_LSB +: RESULT];
   assign node_valid  = bus.mem_a_dout[NODE_VALID_BIT];
   assign go_right    = node_valid && (s1.key >= node_key);

   // The BRAM registers this address on the same edge that loads S1.
   assign bus.mem_a_addr = bus.in_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1         <= '0;
         o_valid    <= 1'b0;
         o          <= '0;
         lookup_cnt <= '0;
         hit_cnt    <= '0;
         b_wr       <= 1'b0;
         b_addr     <= '0;
         b_din      <= '0;
      end else begin
         s1_valid  <= bus.in_valid;
         s1.key    <= bus.in_key;
         s1.addr   <= bus.in_addr;
         s1.result <= bus.in_result;
         s1.hit    <= bus.in_hit;

         o_valid  <= s1_valid;
         o.key    <= s1.key;
         o.addr   <= {s1.addr[ADDR-2:0], go_right};
         o.result <= go_right ? node_result : s1.result;
         o.hit    <= go_right | s1.hit;

         if (s1_valid) begin
            lookup_cnt <= lookup_cnt + CNT'(1);
            if (go_right) hit_cnt <= hit_cnt + CNT'(1);
         end

         b_wr   <= bus.upd_valid;
         b_addr <= bus.upd_addr;
         b_din  <= bus.upd_data;
      end
   end

   assign bus.out_valid  = o_valid;
   assign bus.out_key    = o.key;
   assign bus.out_addr   = o.addr;
   assign bus.out_result = o.result;
   assign bus.out_hit    = o.hit;

   assign bus.mem_b_wr   = b_wr;
   assign bus.mem_b_addr = b_addr;
   assign bus.mem_b_din  = b_din;
   assign bus.upd_ack    = b_wr;

endmodule

// File: tb/tb_lookup_stage.sv
// Bench for lookup_stage: read-first BRAM model, table vectors, corner sequences
// and a randomized run checked against a cycle-stamped reference table.
module tb_lookup_stage;
   import lookup_pkg::*;

   localparam int KEY = 32, RESULT = 39, ADDR = 10, DATA = 72, CNT = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [CNT-1:0] lookup_cnt, hit_cnt;

   always #5 clk = ~clk;

   lookup_stage_if #(.KEY(KEY), .RESULT(RESULT), .ADDR(ADDR), .DATA(DATA)) bus ();

   lookup_stage #(.STAGE_ID(0), .KEY(KEY), .RESULT(RESULT), .ADDR(ADDR),
                  .DATA(DATA), .CNT(CNT)) dut (
      .clk(clk), .rst(rst), .bus(bus), .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt)
   );

   // True dual-port BRAM, 1-cycle read latency, read-first on collision.
   logic [DATA-1:0] bram [0:1023];
   always @(posedge clk) begin
      bus.mem_a_dout <= bram[bus.mem_a_addr];
      if (bus.mem_b_wr) bram[bus.mem_b_addr] <= bus.mem_b_din;
   end

   typedef struct {
      logic              v;
      logic [KEY-1:0]    key;
      logic [ADDR-1:0]   addr;
      logic [RESULT-1:0] res;
      logic              hit;
      logic              go;
   } exp_t;
   typedef struct { logic v; logic [ADDR-1:0] addr; logic [DATA-1:0] data; } wexp_t;
   typedef struct { int stamp; logic [ADDR-1:0] addr; logic [DATA-1:0] data; } pend_t;
   typedef struct {
      node_t             node;
      logic [ADDR-1:0]   naddr;
      logic [KEY-1:0]    key;
      logic [ADDR-1:0]   addr;
      logic [RESULT-1:0] res;
      logic              hit;
      logic [ADDR-1:0]   x_addr;
      logic [RESULT-1:0] x_res;
      logic              x_hit;
   } vec_t;

   node_t  ref_mem [0:1023];
   exp_t   eq[$];
   wexp_t  wq[$];
   pend_t  pend[$];
   logic [CNT-1:0] exp_lk, exp_ht;

   int errors = 0, checks = 0, cyc = 0;

   logic              t_rst, iv, ihit, uv;
   logic [KEY-1:0]    ikey;
   logic [ADDR-1:0]   iaddr, uaddr;
   logic [RESULT-1:0] ires;
   logic [DATA-1:0]   udata;

   logic              o_v, o_hit, o_ack, o_wr;
   logic [KEY-1:0]    o_key;
   logic [ADDR-1:0]   o_addr, o_baddr;
   logic [RESULT-1:0] o_res;
   logic [DATA-1:0]   o_bdin;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Rule-level model: child = 2*addr + go_right; matched node overrides the result.
   function automatic exp_t model(input logic v, input logic [KEY-1:0] key,
                                  input logic [ADDR-1:0] addr,
                                  input logic [RESULT-1:0] res, input logic hit);
      exp_t  r;
      node_t n;
      int    a;
      n     = ref_mem[addr];
      r.go  = n.valid && (key >= n.key);
      a     = int'(addr);
      r.v   = v;
      r.key = key;
      r.addr = ADDR'((a * 2 + (r.go ? 1 : 0)) % (1 << ADDR));
      r.res = r.go ? n.result : res;
      r.hit = r.go || hit;
      return r;
   endfunction

   task automatic push_bubbles();
      exp_t  b;
      wexp_t w;
      b.v = 1'b0; b.key = '0; b.addr = '0; b.res = '0; b.hit = 1'b0; b.go = 1'b0;
      w.v = 1'b0; w.addr = '0; w.data = '0;
      eq.delete(); wq.delete();
      eq.push_back(b); eq.push_back(b);
      wq.push_back(w);
   endtask

   task automatic tick();
      exp_t  r;
      wexp_t w;
      pend_t p;
      @(posedge clk); #1;
      rst = t_rst;
      bus.in_valid = iv; bus.in_key = ikey; bus.in_addr = iaddr;
      bus.in_result = ires; bus.in_hit = ihit;
      bus.upd_valid = uv; bus.upd_addr = uaddr; bus.upd_data = udata;
      // A write requested at cycle s is visible to lookups presented from s+2.
      while (pend.size() > 0 && pend[0].stamp + 2 <= cyc) begin
         ref_mem[pend[0].addr] = pend[0].data;
         void'(pend.pop_front());
      end
      r = model(iv, ikey, iaddr, ires, ihit);
      eq.push_back(r);
      w.v = uv; w.addr = uaddr; w.data = udata;
      wq.push_back(w);
      if (!t_rst && uv) begin
         p.stamp = cyc; p.addr = uaddr; p.data = udata;
         pend.push_back(p);
      end
      @(negedge clk);
      o_v = bus.out_valid; o_key = bus.out_key; o_addr = bus.out_addr;
      o_res = bus.out_result; o_hit = bus.out_hit; o_ack = bus.upd_ack;
      o_wr = bus.mem_b_wr; o_baddr = bus.mem_b_addr; o_bdin = bus.mem_b_din;
      chk("mem_a_addr", bus.mem_a_addr, iaddr);
      if (eq.size() >= 3) begin
         r = eq.pop_front();
         chk("out_valid", o_v, r.v);
         if (r.v) begin
            exp_lk = exp_lk + 1;
            if (r.go) exp_ht = exp_ht + 1;
            chk("out_key", o_key, r.key);
            chk("out_addr", o_addr, r.addr);
            chk("out_result", o_res, r.res);
            chk("out_hit", o_hit, r.hit);
         end
         chk("lookup_cnt", lookup_cnt, exp_lk);
         chk("hit_cnt", hit_cnt, exp_ht);
      end
      if (wq.size() >= 2) begin
         w = wq.pop_front();
         chk("upd_ack", o_ack, w.v);
         chk("mem_b_wr", o_wr, w.v);
         if (w.v) begin
            chk("mem_b_addr", o_baddr, w.addr);
            chk("mem_b_din", o_bdin, w.data);
         end
      end
      if (t_rst) begin
         push_bubbles();
         exp_lk = '0; exp_ht = '0;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      t_rst = 1'b0; iv = 1'b0; uv = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      t_rst = 1'b1; iv = 1'b1; uv = 1'b0; ikey = 32'h1234; iaddr = 10'd1;
      tick(); tick();
      t_rst = 1'b0; iv = 1'b0;
   endtask

   task automatic write_node(input logic [ADDR-1:0] a, input node_t n);
      t_rst = 1'b0; iv = 1'b0; uv = 1'b1; uaddr = a; udata = n;
      tick();
      uv = 1'b0;
   endtask

   function automatic node_t mk(input logic [KEY-1:0] k, input logic [RESULT-1:0] r,
                                input logic v);
      node_t n;
      n.key = k; n.result = r; n.valid = v;
      return n;
   endfunction

   function automatic logic [ADDR-1:0] rand_addr();
      logic [ADDR-1:0] a;
      a = ADDR'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = a | 10'h200;
      return a;
   endfunction

   vec_t vt [6];

   initial begin
      int cnt_v, acks;
      logic [63:0] r64;
      node_t n;
      for (int i = 0; i < 1024; i++) begin
         bram[i] = '0;
         ref_mem[i] = '0;
      end
      t_rst = 1'b1; iv = 1'b0; ihit = 1'b0; uv = 1'b0;
      ikey = '0; iaddr = '0; ires = '0; uaddr = '0; udata = '0;
      exp_lk = '0; exp_ht = '0;

      vt[0] = '{mk(32'h100, 39'h5, 1'b1), 10'd0, 32'h200, 10'd0, 39'h0, 1'b0, 10'd1, 39'h5, 1'b1};
      vt[1] = '{mk(32'h100, 39'h5, 1'b1), 10'd0, 32'h0FF, 10'd0, 39'h7, 1'b1, 10'd0, 39'h7, 1'b1};
      vt[2] = '{mk(32'h0, 39'h9, 1'b0), 10'd0, 32'hFFFF_FFFF, 10'd0, 39'h3, 1'b0, 10'd0, 39'h3, 1'b0};
      vt[3] = '{mk(32'h100, 39'h6, 1'b1), 10'd5, 32'h100, 10'd5, 39'h1, 1'b0, 10'd11, 39'h6, 1'b1};
      vt[4] = '{mk(32'hFFFF_FFFF, 39'h7F_FFFF_FFFF, 1'b1), 10'h3FF, 32'hFFFF_FFFF, 10'h3FF,
                39'h0, 1'b0, 10'h3FF, 39'h7F_FFFF_FFFF, 1'b1};
      vt[5] = '{mk(32'h1, 39'h44, 1'b1), 10'h200, 32'h0, 10'h200, 39'h12, 1'b0, 10'h000, 39'h12, 1'b0};

      do_reset();
      idle(1);
      chk("rst_out_valid", o_v, 1'b0);
      chk("rst_out_hit", o_hit, 1'b0);
      chk("rst_out_key", o_key, 0);
      chk("rst_out_addr", o_addr, 0);
      chk("rst_out_result", o_res, 0);
      chk("rst_upd_ack", o_ack, 1'b0);
      chk("rst_mem_b_wr", o_wr, 1'b0);
      chk("rst_mem_b_addr", o_baddr, 0);
      chk("rst_mem_b_din", o_bdin, 0);
      chk("rst_lookup_cnt", lookup_cnt, 0);
      chk("rst_hit_cnt", hit_cnt, 0);

      // Table vectors: write node, wait for visibility, look up, check two cycles on.
      for (int i = 0; i < 6; i++) begin
         write_node(vt[i].naddr, vt[i].node);
         idle(1);
         iv = 1'b1; ikey = vt[i].key; iaddr = vt[i].addr; ires = vt[i].res; ihit = vt[i].hit;
         tick();
         iv = 1'b0;
         idle(2);
         chk($sformatf("vec%0d_valid", i), o_v, 1'b1);
         chk($sformatf("vec%0d_addr", i), o_addr, vt[i].x_addr);
         chk($sformatf("vec%0d_result", i), o_res, vt[i].x_res);
         chk($sformatf("vec%0d_hit", i), o_hit, vt[i].x_hit);
      end

      // Back-to-back: 16 tokens on consecutive cycles.
      do_reset();
      write_node(10'd0, mk(32'h100, 39'h5, 1'b1));
      idle(1);
      cnt_v = 0;
      ihit = 1'b0; ires = 39'h0; iaddr = 10'd0;
      for (int i = 0; i < 18; i++) begin
         iv = (i < 16); ikey = (i % 2 == 0) ? 32'h200 : 32'h50;
         tick();
         if (o_v) cnt_v++;
      end
      iv = 1'b0;
      idle(1);
      if (o_v) cnt_v++;
      chk("b2b_valid_count", cnt_v, 16);
      chk("b2b_lookup_cnt", lookup_cnt, 16);
      chk("b2b_hit_cnt", hit_cnt, 8);

      // Collision on addr 3: read-first, then the new word two cycles after the request.
      write_node(10'd3, mk(32'h10, 39'h1, 1'b1));
      idle(2);
      acks = 0;
      uv = 1'b1; uaddr = 10'd3; udata = mk(32'h10, 39'h2, 1'b1); iv = 1'b0;
      tick(); acks += int'(o_ack);
      uv = 1'b0; iv = 1'b1; ikey = 32'h20; iaddr = 10'd3; ires = 39'h0; ihit = 1'b0;
      tick(); acks += int'(o_ack);
      tick(); acks += int'(o_ack);
      iv = 1'b0;
      tick(); acks += int'(o_ack);
      chk("collide_old_result", o_res, 39'h1);
      tick(); acks += int'(o_ack);
      chk("visible_new_result", o_res, 39'h2);
      idle(2); acks += int'(o_ack);
      chk("upd_ack_pulses", acks, 1);

      // Reset with tokens in flight.
      iv = 1'b1; iaddr = 10'd0; ikey = 32'h300;
      tick(); tick();
      t_rst = 1'b1;
      tick();
      t_rst = 1'b0; iv = 1'b0;
      cnt_v = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (o_v) cnt_v++;
      end
      chk("midrst_out_valid", cnt_v, 0);
      chk("midrst_lookup_cnt", lookup_cnt, 0);
      chk("midrst_hit_cnt", hit_cnt, 0);

      // Randomized traffic against the reference table.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         t_rst = ($urandom_range(0, 149) == 0);
         iv    = ($urandom_range(0, 3) != 0);
         ikey  = KEY'($urandom_range(0, 20) << 4);
         iaddr = rand_addr();
         r64   = {$urandom, $urandom};
         ires  = r64[RESULT-1:0];
         ihit  = $urandom_range(0, 1);
         uv    = ($urandom_range(0, 2) == 0);
         uaddr = rand_addr();
         r64   = {$urandom, $urandom};
         n     = mk(KEY'($urandom_range(0, 20) << 4), r64[RESULT-1:0], $urandom_range(0, 3) != 0);
         udata = n;
         tick();
      end
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
